// File: rtl/operand_issue_stage_pkg.sv
// Shared types and constants for the operand issue stage.
package operand_issue_stage_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Bit positions of the mode controls inside in_op / out_op.
    localparam int OP_X   = 1;
    localparam int OP_SEL = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/operand_issue_stage_if.sv
// Bundle of the upstream, ALU and downstream signals of the operand issue stage.
interface operand_issue_stage_if
    import operand_issue_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_x;
    logic             alu_sel;
    logic [WIDTH-1:0] alu_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_op;
    logic [LW-1:0]    level;

    modport slave (
        input  in_valid, in_a, in_b, in_op, alu_result, out_ready,
        output in_ready, alu_a, alu_b, alu_x, alu_sel, out_valid, out_data, out_op, level
    );

    modport master (
        output in_valid, in_a, in_b, in_op, alu_result, out_ready,
        input  in_ready, alu_a, alu_b, alu_x, alu_sel, out_valid, out_data, out_op, level
    );

endinterface

// File: rtl/operand_issue_stage_fifo.sv
// Operand FIFO: storage plus wrap-bit pointers; level is the pointer difference.
module issue_fifo #(
    parameter int PW    = 18,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [PW-1:0] wdata,
    output logic [PW-1:0] rdata,
    output logic [LW-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [PW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/operand_issue_stage.sv
// Issue stage: queues operand beats, drives them to an external ALU for one
// cycle and holds the captured result until the consumer takes it.
module operand_issue_stage
    import operand_issue_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    operand_issue_stage_if.slave  bus
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int PW = 2 * WIDTH + 2;

    state_t           state, state_nx;
    logic [LW-1:0]    level;
    logic [PW-1:0]    head;
    logic [1:0]       head_op;
    logic [WIDTH-1:0] head_a, head_b;
    logic             has_head, push, pop, capture, drop;

    logic [WIDTH-1:0] alu_a_q, alu_b_q, out_data_q;
    logic             alu_x_q, alu_sel_q, out_valid_q;
    logic [1:0]       out_op_q;

    // Reset gates in_ready so no beat is taken while rst_n is low.
    assign bus.in_ready = rst_n && (level != LW'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign has_head     = (level != '0);
    assign {head_op, head_b, head_a} = head;

    issue_fifo #(.PW(PW), .DEPTH(DEPTH), .LW(LW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.in_op, bus.in_b, bus.in_a}),
        .rdata (head),
        .level (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (has_head) state_nx = EXEC;
            EXEC:    state_nx = HOLD;
            HOLD:    if (bus.out_ready) state_nx = has_head ? EXEC : IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_comb begin
        pop     = 1'b0;
        capture = 1'b0;
        drop    = 1'b0;
        case (state)
            IDLE:    pop = has_head;
            EXEC:    capture = 1'b1;
            HOLD: begin
                drop = bus.out_ready;
                pop  = bus.out_ready && has_head;
            end
            default: ;
        endcase
        if (flush) begin
            pop     = 1'b0;
            capture = 1'b0;
            drop    = 1'b0;
        end
    end

    // ALU operand registers only change on a pop; flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_x_q   <= 1'b0;
            alu_sel_q <= 1'b0;
        end else if (pop) begin
            alu_a_q   <= head_a;
            alu_b_q   <= head_b;
            alu_x_q   <= head_op[OP_X];
            alu_sel_q <= head_op[OP_SEL];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_op_q    <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_op_q    <= '0;
        end else if (capture) begin
            out_valid_q        <= 1'b1;
            out_data_q         <= bus.alu_result;
            out_op_q[OP_X]     <= alu_x_q;
            out_op_q[OP_SEL]   <= alu_sel_q;
        end else if (drop) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_x     = alu_x_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_op    = out_op_q;
    assign bus.level     = level;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Randomized bench for operand_issue_stage with a transaction-level model and
// directed scenarios pinning latency, backpressure, flush and async reset.
module tb_operand_issue_stage;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] b;
        logic [7:0] a;
    } beat_t;

    logic clk, rst_n, flush;
    int   checks, errors, hs_cnt;

    operand_issue_stage_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    operand_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    // ALU: x=1 gives a&b, x=0 gives a|b.
    assign bus.alu_result = bus.alu_x ? (bus.alu_a & bus.alu_b) : (bus.alu_a | bus.alu_b);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] alu_of(input beat_t bt);
        return bt.op[1] ? (bt.a & bt.b) : (bt.a | bt.b);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: waiting queue, a one-cycle compute slot and a held result.
    beat_t q[$];
    bit    m_exec, m_held;
    beat_t m_exec_b, m_held_b, m_alu;

    task automatic model_step();
        bit    take, slot_free;
        beat_t nb;
        if (!rst_n) begin
            q.delete();
            m_exec = 0;
            m_held = 0;
            m_alu  = '0;
        end else if (flush) begin
            q.delete();
            m_exec = 0;
            m_held = 0;
        end else begin
            take      = bus.in_valid && (q.size() < DEPTH);
            nb        = '{op: bus.in_op, b: bus.in_b, a: bus.in_a};
            slot_free = !m_exec && (!m_held || bus.out_ready);
            if (m_exec) begin
                m_held   = 1;
                m_held_b = m_exec_b;
                m_exec   = 0;
            end else if (m_held && bus.out_ready) begin
                m_held = 0;
            end
            if (slot_free && q.size() > 0) begin
                m_exec_b = q.pop_front();
                m_alu    = m_exec_b;
                m_exec   = 1;
            end
            if (take) q.push_back(nb);
        end
    endtask

    initial begin
        q.delete();
        m_exec = 0; m_held = 0; m_alu = '0; m_exec_b = '0; m_held_b = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    initial begin
        hs_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.out_valid && bus.out_ready) hs_cnt++;
                chk("level",     32'(bus.level), q.size());
                chk("in_ready",  32'(bus.in_ready), 32'(q.size() < DEPTH));
                chk("out_valid", 32'(bus.out_valid), 32'(m_held));
                chk("alu_a",     32'(bus.alu_a), 32'(m_alu.a));
                chk("alu_b",     32'(bus.alu_b), 32'(m_alu.b));
                chk("alu_x",     32'(bus.alu_x), 32'(m_alu.op[1]));
                chk("alu_sel",   32'(bus.alu_sel), 32'(m_alu.op[0]));
                if (m_held) begin
                    chk("out_data", 32'(bus.out_data), 32'(alu_of(m_held_b)));
                    chk("out_op",   32'(bus.out_op), 32'(m_held_b.op));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
    endtask

    // Presents a beat and returns #1 after the edge that accepted it.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        bit acc;
        acc = 0;
        present(a, b, op);
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
        end
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: beat %0h/%0h not accepted within 50 cycles", a, b);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #17;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
        step();
    endtask

    initial begin
        int hs0;
        bit acc;
        checks = 0; errors = 0;
        rst_n = 1'b0; flush = 1'b0;
        bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.in_op = 0; bus.out_ready = 0;
        #13;
        chk("rst_in_ready",  32'(bus.in_ready), 32'd0);
        chk("rst_level",     32'(bus.level), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data), 32'd0);
        chk("rst_alu_a",     32'(bus.alu_a), 32'd0);
        reset_dut();

        // Scenario 1: beat presented at edge N (accepted into FIFO at N+1), result valid from N+3.
        bus.out_ready = 1'b1;
        present(8'hF0, 8'h3C, 2'b10);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("s1_not_yet_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("s1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("s1_out_data",  32'(bus.out_data), 32'h30);
        chk("s1_out_op",    32'(bus.out_op), 32'd2);
        step(); repeat (3) step();

        // Scenario 2: x=0 path.
        present(8'hF0, 8'h3C, 2'b00);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("s2_out_valid", 32'(bus.out_valid), 32'd1);
        chk("s2_out_data",  32'(bus.out_data), 32'hFC);
        chk("s2_out_op",    32'(bus.out_op), 32'd0);
        step(); repeat (3) step();

        // Scenario 3: fill the FIFO behind a held result; the extra beat waits.
        bus.out_ready = 1'b0;
        hs0 = hs_cnt;
        for (int i = 0; i < 5; i++) send(8'(8'h11 * (i + 1)), 8'(8'h0F << i), 2'(i));
        chk("s3_level_full", 32'(bus.level), 32'd4);
        chk("s3_in_ready_low", 32'(bus.in_ready), 32'd0);
        present(8'hA5, 8'h5A, 2'b01);
        repeat (3) step();
        chk("s3_still_blocked", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
        end
        chk("s3_sixth_accepted", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
        repeat (16) step();
        chk("s3_delivered", 32'(hs_cnt - hs0), 32'd6);

        // Scenario 4: backpressure for 10 cycles, then release.
        bus.out_ready = 1'b0;
        send(8'hAA, 8'h0F, 2'b10);
        send(8'h55, 8'h0F, 2'b00);
        step(); step();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("s4_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("s4_hold_data",  32'(bus.out_data), 32'h0A);
            chk("s4_hold_op",    32'(bus.out_op), 32'd2);
            @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("s4_gap", 32'(bus.out_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("s4_next_valid", 32'(bus.out_valid), 32'd1);
        chk("s4_next_data",  32'(bus.out_data), 32'h5F);
        step(); repeat (3) step();

        // Scenario 5: flush with a held result and three queued beats.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(8'h30 + i), 8'hC3, 2'b11);
        repeat (3) step();
        chk("s5_level_pre",     32'(bus.level), 32'd3);
        chk("s5_out_valid_pre", 32'(bus.out_valid), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("s5_level_post",     32'(bus.level), 32'd0);
        chk("s5_out_valid_post", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("s5_no_stale", 32'(bus.out_valid), 32'd0);
        end
        step();

        // Scenario 6: async reset while the ALU registers are loaded (EXEC).
        present(8'h12, 8'h34, 2'b11);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(posedge clk); #2;
        chk("s6_alu_loaded", 32'(bus.alu_a), 32'h12);
        rst_n = 1'b0;
        #1;
        chk("s6_in_ready", 32'(bus.in_ready), 32'd0);
        chk("s6_level",    32'(bus.level), 32'd0);
        chk("s6_out_valid",32'(bus.out_valid), 32'd0);
        chk("s6_out_data", 32'(bus.out_data), 32'd0);
        chk("s6_out_op",   32'(bus.out_op), 32'd0);
        chk("s6_alu_a",    32'(bus.alu_a), 32'd0);
        chk("s6_alu_b",    32'(bus.alu_b), 32'd0);
        chk("s6_alu_x",    32'(bus.alu_x), 32'd0);
        chk("s6_alu_sel",  32'(bus.alu_sel), 32'd0);
        reset_dut();

        // Random traffic with bursts of backpressure and occasional flushes.
        for (int w = 0; w < 15; w++) begin
            int rdy_pct;
            rdy_pct = (w % 3 == 0) ? 20 : 80;
            for (int c = 0; c < 200; c++) begin
                bus.in_valid  = ($urandom_range(99) < 60);
                bus.in_a      = 8'($urandom);
                bus.in_b      = 8'($urandom);
                bus.in_op     = 2'($urandom);
                bus.out_ready = ($urandom_range(99) < rdy_pct);
                flush         = ($urandom_range(63) == 0);
                step();
            end
        end
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) step();
        chk("drain_level", 32'(bus.level), 32'd0);
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
